yarp_wb_arbiter: RTL and testbench

Write-back arbiter and register scoreboard for the yarp core's 32x32 register file. It shares the register file's single write port between NUM_REQ write-back sources (ALU, load unit, CSR unit) using round-robin arbitration. The write command is registered. Per-register pending-write counters tell the decode stage whether an operand is still in flight. It sits between the execute/memory stages and the register file, and drives the file's `wr_en`/`rd_addr`/`wr_data` inputs.

---
 rtl/yarp_pkg.sv | 18 +
 rtl/yarp_rr_arbiter.sv | 45 ++++
 rtl/yarp_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_yarp_wb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the yarp write-back path: requester count, write-back
// payload and the fixed requester ordering.
package yarp_pkg;

  localparam int YARP_NUM_WB_REQ = 3;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2
  } wb_req_idx_e;

endpackage

// File: rtl/yarp_rr_arbiter.sv
// Round-robin grant over N requesters. The search starts one past the last
// granted index; no grant is issued while reset is asserted.
module yarp_rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx;
  logic             found;
  int               sum;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    sum       = 0;
    for (int k = 1; k <= N; k++) begin
      sum = int'(last_q) + k;
      if (sum >= N) sum = sum - N;
      idx = IDX_W'(sum);
      if (!found && !reset && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    last_d = found ? gnt_idx_o : last_q;
  end

  // Reset to the highest index so requester 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= IDX_W'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/yarp_wb_arbiter.sv
// Write-back arbiter and register scoreboard for the 32x32 register file.
// Define YARP_WB_FWD_EN to add the write-stage forwarding ports.
module yarp_wb_arbiter
  import yarp_pkg::*;
#(
  parameter int NUM_REQ = YARP_NUM_WB_REQ,
  parameter int CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0][4:0]  req_rd_addr_i,
  input  logic [NUM_REQ-1:0][31:0] req_data_i,
  input  logic                     issue_valid_i,
  input  logic [4:0]               issue_rd_i,
  output logic                     issue_stall_o,
  input  logic [4:0]               rs1_addr_i,
  input  logic [4:0]               rs2_addr_i,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  output logic                     wr_en_o,
  output logic [4:0]               wr_rd_addr_o,
  output logic [31:0]              wr_data_o
`ifdef YARP_WB_FWD_EN
  ,
  output logic                     rs1_fwd_o,
  output logic                     rs2_fwd_o,
  output logic [31:0]              fwd_data_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  wb_req_t            sel_req;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_rd_addr_q, wr_rd_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic [31:0][CNT_W-1:0] cnt;

  yarp_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid_i),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;

  // x0 writes are accepted but never enabled, so they never touch a counter.
  always_comb begin
    sel_req.rd_addr = req_rd_addr_i[gnt_idx];
    sel_req.data    = req_data_i[gnt_idx];
    wr_en_d         = 1'b0;
    wr_rd_addr_d    = wr_rd_addr_q;
    wr_data_d       = wr_data_q;
    if (|gnt) begin
      wr_en_d      = (sel_req.rd_addr != 5'd0);
      wr_rd_addr_d = sel_req.rd_addr;
      wr_data_d    = sel_req.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_rd_addr_q <= 5'd0;
      wr_data_q    <= 32'd0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_rd_addr_q <= wr_rd_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_rd_addr_o = wr_rd_addr_q;
  assign wr_data_o    = wr_data_q;

  assign cnt[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc, dec;

    assign inc = issue_valid_i & ~issue_stall_o & (issue_rd_i == 5'(gi));
    assign dec = wr_en_q & (wr_rd_addr_q == 5'(gi));

    always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec)                      cnt_d = cnt_q + 1'b1;
      else if (!inc && dec && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt[gi] = cnt_q;

    // A commit with nothing pending means a requester wrote an unissued rd.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      !(dec && cnt_q == '0))
      else $error("write-back commit to x%0d with no pending issue", gi);
  end

  assign issue_stall_o = issue_valid_i & (cnt[issue_rd_i] == CNT_MAX);

`ifdef YARP_WB_FWD_EN
  assign rs1_fwd_o  = wr_en_q & (wr_rd_addr_q == rs1_addr_i) & (rs1_addr_i != 5'd0);
  assign rs2_fwd_o  = wr_en_q & (wr_rd_addr_q == rs2_addr_i) & (rs2_addr_i != 5'd0);
  assign fwd_data_o = wr_data_q;
  // The last outstanding write is on the forward path, so the operand is usable.
  assign rs1_busy_o = (cnt[rs1_addr_i] != '0) &
                      ~(rs1_fwd_o & (cnt[rs1_addr_i] == CNT_W'(1)));
  assign rs2_busy_o = (cnt[rs2_addr_i] != '0) &
                      ~(rs2_fwd_o & (cnt[rs2_addr_i] == CNT_W'(1)));
`else
  assign rs1_busy_o = (cnt[rs1_addr_i] != '0);
  assign rs2_busy_o = (cnt[rs2_addr_i] != '0);
`endif

endmodule

// File: tb/tb_yarp_wb_arbiter.sv
// Randomized bench for yarp_wb_arbiter against a pending-count reference model;
// also covers the YARP_WB_FWD_EN build when that macro is defined.
module tb_yarp_wb_arbiter;
  import yarp_pkg::*;

  localparam int N    = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid_i;
  logic [N-1:0]        req_ready_o;
  logic [N-1:0][4:0]   req_rd_addr_i;
  logic [N-1:0][31:0]  req_data_i;
  logic                issue_valid_i;
  logic [4:0]          issue_rd_i;
  logic                issue_stall_o;
  logic [4:0]          rs1_addr_i, rs2_addr_i;
  logic                rs1_busy_o, rs2_busy_o;
  logic                wr_en_o;
  logic [4:0]          wr_rd_addr_o;
  logic [31:0]         wr_data_o;
`ifdef YARP_WB_FWD_EN
  logic                rs1_fwd_o, rs2_fwd_o;
  logic [31:0]         fwd_data_o;
`endif

  always #5 clk = ~clk;

  yarp_wb_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_rd_addr_i (req_rd_addr_i),
    .req_data_i    (req_data_i),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_stall_o (issue_stall_o),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_busy_o    (rs1_busy_o),
    .rs2_busy_o    (rs2_busy_o),
    .wr_en_o       (wr_en_o),
    .wr_rd_addr_o  (wr_rd_addr_o),
    .wr_data_o     (wr_data_o)
`ifdef YARP_WB_FWD_EN
    ,
    .rs1_fwd_o     (rs1_fwd_o),
    .rs2_fwd_o     (rs2_fwd_o),
    .fwd_data_o    (fwd_data_o)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          m_last;
  int          m_cnt[32];
  int          tokens[32];
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last    = N - 1;
    m_wr_en   = 1'b0;
    m_wr_addr = 5'd0;
    m_wr_data = 32'd0;
    for (int r = 0; r < 32; r++) begin
      m_cnt[r]  = 0;
      tokens[r] = 0;
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid_i[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic exp_fwd(input logic [4:0] rs);
    return m_wr_en && (m_wr_addr == rs) && (rs != 5'd0);
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs);
`ifdef YARP_WB_FWD_EN
    if (exp_fwd(rs) && m_cnt[rs] == 1) return 1'b0;
`endif
    return m_cnt[rs] != 0;
  endfunction

  task automatic clear_inputs();
    req_valid_i   = '0;
    req_rd_addr_i = '0;
    req_data_i    = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = 5'd0;
    rs1_addr_i    = 5'd0;
    rs2_addr_i    = 5'd0;
  endtask

  task automatic post_req(input int i, input logic [4:0] rd, input logic [31:0] data);
    req_valid_i[i]   = 1'b1;
    req_rd_addr_i[i] = rd;
    req_data_i[i]    = data;
    if (rd != 5'd0) tokens[rd]--;
  endtask

  // One clock: combinational outputs checked at the falling edge, write stage
  // checked just after the rising edge. Inputs must be stable across the call.
  task automatic cycle(output int g);
    int   ge;
    logic stall, acc;
    @(negedge clk);
    ge    = exp_grant();
    stall = issue_valid_i && (m_cnt[issue_rd_i] == CMAX) && (issue_rd_i != 5'd0);
    check("ready", 64'(req_ready_o), (ge < 0) ? 64'd0 : (64'd1 << ge));
    check("stall", 64'(issue_stall_o), 64'(stall));
    check("rs1_busy", 64'(rs1_busy_o), 64'(exp_busy(rs1_addr_i)));
    check("rs2_busy", 64'(rs2_busy_o), 64'(exp_busy(rs2_addr_i)));
`ifdef YARP_WB_FWD_EN
    check("rs1_fwd", 64'(rs1_fwd_o), 64'(exp_fwd(rs1_addr_i)));
    check("rs2_fwd", 64'(rs2_fwd_o), 64'(exp_fwd(rs2_addr_i)));
    check("fwd_data", 64'(fwd_data_o), 64'(m_wr_data));
`endif
    @(posedge clk);
    acc = issue_valid_i && !stall && (issue_rd_i != 5'd0);
    if (acc) begin
      m_cnt[issue_rd_i]++;
      tokens[issue_rd_i]++;
    end
    if (m_wr_en && m_cnt[m_wr_addr] > 0) m_cnt[m_wr_addr]--;
    if (ge >= 0) begin
      m_last    = ge;
      m_wr_en   = (req_rd_addr_i[ge] != 5'd0);
      m_wr_addr = req_rd_addr_i[ge];
      m_wr_data = req_data_i[ge];
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
    check("wr_en", 64'(wr_en_o), 64'(m_wr_en));
    check("wr_addr", 64'(wr_rd_addr_o), 64'(m_wr_addr));
    check("wr_data", 64'(wr_data_o), 64'(m_wr_data));
    g = ge;
  endtask

  function automatic logic [4:0] pick_rd();
    int start;
    start = $urandom_range(1, 9);
    if ($urandom_range(0, 7) == 0) return 5'd0;
    for (int k = 0; k < 9; k++) begin
      int r;
      r = 1 + (start - 1 + k) % 9;
      if (tokens[r] > 0) return 5'(r);
    end
    return 5'd0;
  endfunction

  initial begin
    int g;
    logic [4:0] rd;

    clear_inputs();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_wr_addr", 64'(wr_rd_addr_o), 64'd0);
    check("rst_wr_data", 64'(wr_data_o), 64'd0);
    req_valid_i = '1;
    #1;
    check("rst_ready", 64'(req_ready_o), 64'd0);
    reset = 1'b0;

    // Three-way contention straight out of reset, all to x0.
    for (int k = 0; k < 6; k++) begin
      cycle(g);
      check("rr_seq", 64'(g), 64'(k % N));
      check("x0_no_wr", 64'(wr_en_o), 64'd0);
    end
    clear_inputs();

    // Issue to x0 never stalls and never marks x0 busy.
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd0;
    #1;
    check("x0_stall", 64'(issue_stall_o), 64'd0);
    cycle(g);
    check("x0_busy", 64'(rs1_busy_o), 64'd0);
    clear_inputs();

    // Single ALU write of x5.
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd5;
    rs1_addr_i    = 5'd5;
    cycle(g);
    issue_valid_i = 1'b0;
    post_req(int'(WB_ALU), 5'd5, 32'hDEADBEEF);
    cycle(g);
    check("alu_gnt", 64'(g), 64'(WB_ALU));
    req_valid_i = '0;
    check("alu_wr_en", 64'(wr_en_o), 64'd1);
    check("alu_wr_addr", 64'(wr_rd_addr_o), 64'd5);
    check("alu_wr_data", 64'(wr_data_o), 64'hDEADBEEF);
    cycle(g);
    check("alu_wr_off", 64'(wr_en_o), 64'd0);
    check("alu_busy_clr", 64'(rs1_busy_o), 64'd0);

    // x7: two issues, then issue alongside a commit, then saturate.
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd7;
    cycle(g);
    cycle(g);
    issue_valid_i = 1'b0;
    post_req(int'(WB_CSR), 5'd7, 32'h0000_0777);
    cycle(g);
    req_valid_i   = '0;
    issue_valid_i = 1'b1;
    cycle(g);
    cycle(g);
    #1;
    check("x7_stall_sat", 64'(issue_stall_o), 64'd1);
    cycle(g);
    clear_inputs();

    // LSU write of x9 with rs1 watching it.
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd9;
    rs1_addr_i    = 5'd9;
    cycle(g);
    issue_valid_i = 1'b0;
    post_req(int'(WB_LSU), 5'd9, 32'h1234_5678);
    cycle(g);
    req_valid_i = '0;
`ifdef YARP_WB_FWD_EN
    check("x9_busy_t1", 64'(rs1_busy_o), 64'd0);
    check("x9_fwd_t1", 64'(rs1_fwd_o), 64'd1);
`else
    check("x9_busy_t1", 64'(rs1_busy_o), 64'd1);
`endif
    cycle(g);
    check("x9_busy_t2", 64'(rs1_busy_o), 64'd0);

    // Random traffic; requesters only write registers with a pending issue.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i] && $urandom_range(0, 1) == 1) begin
          rd = pick_rd();
          post_req(i, rd, $urandom);
        end
      end
      issue_valid_i = ($urandom_range(0, 1) == 1);
      issue_rd_i    = 5'($urandom_range(0, 5));
      rs1_addr_i    = 5'($urandom_range(0, 9));
      rs2_addr_i    = 5'($urandom_range(0, 9));
      cycle(g);
      if (g >= 0) req_valid_i[g] = 1'b0;
    end
    clear_inputs();

    // Reset while a write is in flight.
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd3;
    cycle(g);
    issue_valid_i = 1'b0;
    post_req(int'(WB_CSR), 5'd3, 32'hCAFE_F00D);
    rs1_addr_i = 5'd3;
    rs2_addr_i = 5'd7;
    cycle(g);
    check("pre_rst_wr_en", 64'(wr_en_o), 64'd1);
    req_valid_i   = '1;
    req_rd_addr_i = '0;
    reset         = 1'b1;
    #1;
    check("mid_rst_wr_en", 64'(wr_en_o), 64'd0);
    check("mid_rst_busy1", 64'(rs1_busy_o), 64'd0);
    check("mid_rst_busy2", 64'(rs2_busy_o), 64'd0);
    check("mid_rst_ready", 64'(req_ready_o), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(g);
    check("post_rst_gnt", 64'(g), 64'd0);
    cycle(g);
    check("post_rst_gnt2", 64'(g), 64'd1);
    clear_inputs();
    cycle(g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
